// File: rtl/led_pattern_pkg.sv
// Shared key indices, pattern codes and bounce direction
// for the LED pattern controller.
package led_pattern_pkg;

  localparam int KEY_UP   = 0;
  localparam int KEY_DOWN = 1;
  localparam int KEY_SEL  = 2;
  localparam int KEY_AUTO = 3;

  localparam int SPEED_LEVELS = 4;

  typedef enum logic [1:0] {
    PAT_SHIFT_L = 2'd0,
    PAT_SHIFT_R = 2'd1,
    PAT_BOUNCE  = 2'd2,
    PAT_BLINK   = 2'd3
  } pat_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

endpackage

// File: rtl/led_pattern_ctrl_step_timer.sv
// Programmable step period counter: period is
// STEP_BASE_CYC << (3 - speed), tick on the wrap cycle.
module step_timer #(
  parameter int STEP_BASE_CYC = 6_250_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic [1:0] speed,
  output logic       tick
);

  localparam int CW = $clog2(STEP_BASE_CYC * 8);

  localparam logic [CW-1:0] L0 = CW'(STEP_BASE_CYC * 8 - 1);
  localparam logic [CW-1:0] L1 = CW'(STEP_BASE_CYC * 4 - 1);
  localparam logic [CW-1:0] L2 = CW'(STEP_BASE_CYC * 2 - 1);
  localparam logic [CW-1:0] L3 = CW'(STEP_BASE_CYC - 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_last;

  always_comb begin
    w_last = L0;
    case (speed)
      2'd0:    w_last = L0;
      2'd1:    w_last = L1;
      2'd2:    w_last = L2;
      default: w_last = L3;
    endcase
  end

  assign tick = (r_cnt == w_last);

  always_ff @(posedge clk) begin
    if (rst || clear || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED pattern controller: pattern/speed/auto registers
// and the LED next-state logic driven by key pulses.
module led_pattern_ctrl
  import led_pattern_pkg::*;
#(
  parameter int LED_W         = 8,
  parameter int STEP_BASE_CYC = 6_250_000,
  parameter int AUTO_STEPS    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       key_pulse,
  output logic [LED_W-1:0] led,
  output logic [1:0]       pattern_idx,
  output logic [1:0]       speed,
  output logic             auto_on,
  output logic             step_tick
);

  localparam int AW = (AUTO_STEPS > 1) ? $clog2(AUTO_STEPS) : 1;
  localparam logic [AW-1:0] A_LAST = AW'(AUTO_STEPS - 1);

  logic [LED_W-1:0] r_led, w_led_nxt;
  pat_e             r_pat, w_pat_nxt;
  logic [1:0]       r_speed, w_speed_nxt;
  logic             r_auto, w_auto_nxt;
  dir_e             r_dir, w_dir_nxt;
  logic [AW-1:0]    r_acnt, w_acnt_nxt;

  logic w_up, w_dn, w_sel, w_auto;
  logic w_man, w_wrap, w_step, w_adv;

  function automatic logic [LED_W-1:0] pat_init(pat_e p);
    logic [LED_W-1:0] v;
    v = LED_W'(1);
    case (p)
      PAT_SHIFT_R: v = {1'b1, {(LED_W-1){1'b0}}};
      PAT_BLINK:   v = '1;
      default:     v = LED_W'(1);
    endcase
    return v;
  endfunction

  assign w_up   = key_pulse[KEY_UP];
  assign w_dn   = key_pulse[KEY_DOWN];
  assign w_sel  = key_pulse[KEY_SEL];
  assign w_auto = key_pulse[KEY_AUTO];
  assign w_man  = w_up ^ w_dn;

  step_timer #(
    .STEP_BASE_CYC(STEP_BASE_CYC)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(w_sel | w_man),
    .speed(r_speed),
    .tick (w_wrap)
  );

  // A wrap is dropped when sel restarts the period or the pattern changes.
  assign w_step = w_wrap & ~w_sel & ~w_man;
  assign w_adv  = r_auto & ~w_auto & (r_acnt == A_LAST);

  always_comb begin
    w_led_nxt   = r_led;
    w_pat_nxt   = r_pat;
    w_speed_nxt = r_speed;
    w_auto_nxt  = r_auto;
    w_dir_nxt   = r_dir;
    w_acnt_nxt  = r_acnt;

    if (w_sel) begin
      w_speed_nxt = r_speed + 2'd1;
    end
    if (w_auto) begin
      w_auto_nxt = ~r_auto;
      w_acnt_nxt = '0;
    end

    if (w_man) begin
      w_pat_nxt  = w_up ? pat_e'(r_pat + 2'd1)
                        : pat_e'(r_pat - 2'd1);
      w_led_nxt  = pat_init(w_pat_nxt);
      w_dir_nxt  = DIR_LEFT;
      w_acnt_nxt = '0;
    end else if (w_step && w_adv) begin
      w_pat_nxt  = pat_e'(r_pat + 2'd1);
      w_led_nxt  = pat_init(w_pat_nxt);
      w_dir_nxt  = DIR_LEFT;
      w_acnt_nxt = '0;
    end else if (w_step) begin
      if (r_auto && !w_auto) begin
        w_acnt_nxt = r_acnt + 1'b1;
      end
      case (r_pat)
        PAT_SHIFT_L: w_led_nxt = {r_led[LED_W-2:0], r_led[LED_W-1]};
        PAT_SHIFT_R: w_led_nxt = {r_led[0], r_led[LED_W-1:1]};
        PAT_BOUNCE: begin
          if (r_dir == DIR_LEFT) begin
            if (r_led[LED_W-1]) begin
              w_led_nxt = r_led >> 1;
              w_dir_nxt = DIR_RIGHT;
            end else begin
              w_led_nxt = r_led << 1;
            end
          end else begin
            if (r_led[0]) begin
              w_led_nxt = r_led << 1;
              w_dir_nxt = DIR_LEFT;
            end else begin
              w_led_nxt = r_led >> 1;
            end
          end
        end
        default: w_led_nxt = ~r_led;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_led   <= LED_W'(1);
      r_pat   <= PAT_SHIFT_L;
      r_speed <= 2'd0;
      r_auto  <= 1'b0;
      r_dir   <= DIR_LEFT;
      r_acnt  <= '0;
    end else begin
      r_led   <= w_led_nxt;
      r_pat   <= w_pat_nxt;
      r_speed <= w_speed_nxt;
      r_auto  <= w_auto_nxt;
      r_dir   <= w_dir_nxt;
      r_acnt  <= w_acnt_nxt;
    end
  end

  assign led         = r_led;
  assign pattern_idx = r_pat;
  assign speed       = r_speed;
  assign auto_on     = r_auto;
  assign step_tick   = w_step & ~rst;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl: directed table, corner
// sequences and random keys against a reference model.
module tb_led_pattern_ctrl;
  import led_pattern_pkg::*;

  localparam int W    = 8;
  localparam int BASE = 4;
  localparam int AST  = 3;

  localparam logic [3:0] K_NONE = 4'b0000;
  localparam logic [3:0] K_UP   = 4'b0001;
  localparam logic [3:0] K_DN   = 4'b0010;
  localparam logic [3:0] K_SEL  = 4'b0100;
  localparam logic [3:0] K_AUTO = 4'b1000;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   key_pulse;
  logic [W-1:0] led;
  logic [1:0]   pattern_idx;
  logic [1:0]   speed;
  logic         auto_on;
  logic         step_tick;

  always #5 clk = ~clk;

  led_pattern_ctrl #(
    .LED_W(W), .STEP_BASE_CYC(BASE), .AUTO_STEPS(AST)
  ) dut (
    .clk(clk), .rst(rst), .key_pulse(key_pulse),
    .led(led), .pattern_idx(pattern_idx), .speed(speed),
    .auto_on(auto_on), .step_tick(step_tick)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference state: pattern, speed, auto, steps since pattern init
  int m_pat, m_speed, m_k, m_cnt, m_acnt;
  bit m_auto;
  bit m_check = 0;

  logic [W-1:0] s_led;
  logic [1:0]   s_pat, s_speed;
  logic         s_auto, s_tick;

  typedef struct {
    logic [3:0] keys;
    logic [1:0] pat;
    logic [1:0] spd;
    logic [7:0] led;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_led(int pat, int k);
    int p;
    logic [7:0] v;
    case (pat)
      0: v = 8'h01 << (k % W);
      1: v = 8'h80 >> (k % W);
      2: begin
        p = k % (2 * W - 2);
        v = (p < W) ? (8'h01 << p) : (8'h01 << (2 * W - 2 - p));
      end
      default: v = ((k % 2) == 0) ? 8'hFF : 8'h00;
    endcase
    return v;
  endfunction

  task automatic cyc(input logic [3:0] keys, input logic r);
    int  period;
    bit  wrap, man, sel, aut, old_auto, etick;
    @(negedge clk);
    key_pulse = keys;
    rst = r;
    #1;
    s_led = led; s_pat = pattern_idx; s_speed = speed;
    s_auto = auto_on; s_tick = step_tick;
    period = BASE << (3 - m_speed);
    wrap = (m_cnt == period - 1);
    sel  = keys[KEY_SEL];
    aut  = keys[KEY_AUTO];
    man  = keys[KEY_UP] ^ keys[KEY_DOWN];
    etick = !r && wrap && !sel && !man;
    if (m_check) begin
      check("model", {18'd0, s_led, s_pat, s_speed, s_auto, s_tick},
            {18'd0, exp_led(m_pat, m_k), 2'(m_pat), 2'(m_speed),
             1'(m_auto), 1'(etick)});
    end
    @(posedge clk);
    if (r) begin
      m_pat = 0; m_speed = 0; m_auto = 0;
      m_k = 0; m_cnt = 0; m_acnt = 0;
    end else begin
      old_auto = m_auto;
      m_cnt = (sel || man || wrap) ? 0 : m_cnt + 1;
      if (sel) m_speed = (m_speed + 1) % 4;
      if (aut) begin
        m_auto = !m_auto;
        m_acnt = 0;
      end
      if (man) begin
        m_pat = (m_pat + (keys[KEY_UP] ? 1 : 3)) % 4;
        m_k = 0;
        m_acnt = 0;
      end else if (wrap && !sel) begin
        if (old_auto && !aut) m_acnt++;
        if (m_acnt == AST) begin
          m_pat = (m_pat + 1) % 4;
          m_k = 0;
          m_acnt = 0;
        end else begin
          m_k++;
        end
      end
    end
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      cyc(K_NONE, 1'b0);
      n++;
    end while (!s_tick && n < 200);
    if (!s_tick) begin
      n_cmp++;
      n_bad++;
      $display("FAIL tick_timeout: no step_tick in %0d cycles", n);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] bseq[16];
    logic [1:0] aseq[6];
    logic [1:0] useq[3];
    logic [3:0] k;

    tbl[0]  = '{K_UP,        2'd1, 2'd0, 8'h80};
    tbl[1]  = '{K_DN,        2'd0, 2'd0, 8'h01};
    tbl[2]  = '{K_DN,        2'd3, 2'd0, 8'hFF};
    tbl[3]  = '{K_UP | K_DN, 2'd3, 2'd0, 8'hFF};
    tbl[4]  = '{K_SEL,       2'd3, 2'd1, 8'hFF};
    tbl[5]  = '{K_SEL,       2'd3, 2'd2, 8'hFF};
    tbl[6]  = '{K_SEL,       2'd3, 2'd3, 8'hFF};
    tbl[7]  = '{K_DN,        2'd2, 2'd3, 8'h01};
    tbl[8]  = '{K_UP,        2'd3, 2'd3, 8'hFF};
    tbl[9]  = '{K_UP,        2'd0, 2'd3, 8'h01};
    tbl[10] = '{K_SEL,       2'd0, 2'd0, 8'h01};

    bseq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
             8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
    aseq = '{2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
    useq = '{2'd1, 2'd1, 2'd2};

    key_pulse = K_NONE;
    rst = 1'b1;
    m_pat = 0; m_speed = 0; m_auto = 0;
    m_k = 0; m_cnt = 0; m_acnt = 0;

    // reset and first step
    repeat (3) cyc(K_NONE, 1'b1);
    m_check = 1;
    cyc(K_NONE, 1'b0);
    check("reset_state", {s_led, s_pat, s_speed, s_auto, s_tick},
          {8'h01, 2'd0, 2'd0, 1'b0, 1'b0});
    wait_tick(n);
    check("first_tick_delay", n, 31);
    cyc(K_NONE, 1'b0);
    check("first_step_led", s_led, 8'h02);

    // key table
    foreach (tbl[i]) begin
      cyc(tbl[i].keys, 1'b0);
      cyc(K_NONE, 1'b0);
      check($sformatf("tbl%0d", i), {s_pat, s_speed, s_led, s_tick},
            {tbl[i].pat, tbl[i].spd, tbl[i].led, 1'b0});
    end

    // fast speed period and sel on a wrap cycle
    repeat (3) cyc(K_SEL, 1'b0);
    wait_tick(n);
    wait_tick(n);
    check("speed3_period", n, 4);
    repeat (3) cyc(K_NONE, 1'b0);
    cyc(K_SEL, 1'b0);
    check("sel_on_wrap_tick", s_tick, 1'b0);
    cyc(K_NONE, 1'b0);
    check("sel_wrap_speed", s_speed, 2'd0);

    // bounce at speed 3
    cyc(K_UP, 1'b0);
    cyc(K_UP, 1'b0);
    repeat (3) cyc(K_SEL, 1'b0);
    cyc(K_NONE, 1'b0);
    check("bounce_init", {s_pat, s_speed, s_led},
          {2'd2, 2'd3, 8'h01});
    for (int i = 0; i < 16; i++) begin
      wait_tick(n);
      cyc(K_NONE, 1'b0);
      check($sformatf("bounce%0d", i), s_led, bseq[i]);
    end

    // auto cycling, manual up resets the auto count, then reset
    cyc(K_AUTO, 1'b0);
    cyc(K_NONE, 1'b0);
    check("auto_on", s_auto, 1'b1);
    for (int i = 0; i < 6; i++) begin
      wait_tick(n);
      cyc(K_NONE, 1'b0);
      check($sformatf("auto%0d", i), s_pat, aseq[i]);
    end
    repeat (2) begin
      wait_tick(n);
      cyc(K_NONE, 1'b0);
    end
    cyc(K_UP, 1'b0);
    cyc(K_NONE, 1'b0);
    check("auto_up", {s_pat, s_led}, {2'd1, 8'h80});
    for (int i = 0; i < 3; i++) begin
      wait_tick(n);
      cyc(K_NONE, 1'b0);
      check($sformatf("auto_after_up%0d", i), s_pat, useq[i]);
    end
    repeat (2) cyc(K_NONE, 1'b0);
    cyc(K_NONE, 1'b1);
    cyc(K_NONE, 1'b0);
    check("mid_reset", {s_led, s_pat, s_speed, s_auto, s_tick},
          {8'h01, 2'd0, 2'd0, 1'b0, 1'b0});

    // random keys against the model
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++) k[b] = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0 && m_speed < 2) k[KEY_SEL] = 1'b1;
      cyc(k, $urandom_range(0, 399) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
